// File: rtl/sw_event_pkg.sv
// Shared sizing and event record layout for the switch event queue.
// A record is {switch index, new level}; the FIFO stores it as EV_W bits.
package sw_event_pkg;

    localparam int NUM_SW = 17;
    localparam int IDX_W  = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int EV_W   = IDX_W + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             level;
    } ev_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with exact occupancy count.
// A push is accepted while full only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    // Head is forced to zero when empty so the output idles at its reset value.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sw_event_queue.sv
// Turns debounced switch level changes into {index, level} event records and
// queues them for a valid/ready consumer; one pending record per switch.
module sw_event_queue
    import sw_event_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_db,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [IDX_W-1:0]  ev_idx,
    output logic              ev_level,
    output logic [CNT_W-1:0]  ev_count,
    output logic              ev_merged,
    input  logic              clr_merged
);

    logic [NUM_SW-1:0] prev_sw_q;
    logic [NUM_SW-1:0] pend_q, pend_d;
    logic [NUM_SW-1:0] plev_q, plev_d;
    logic              merged_q, merged_d;

    logic [NUM_SW-1:0] chg, push_sel, merge_vec;
    logic [IDX_W-1:0]  push_idx;
    logic              push_any, push, pop, fifo_full;
    ev_rec_t           push_rec, head_rec;

    assign chg      = sw_db ^ prev_sw_q;
    assign pop      = ev_valid && ev_ready;
    assign push_any = (pend_q != '0);
    assign push     = push_any && (!fifo_full || pop);
    // Isolate the lowest set pending bit; only that switch can be pushed.
    assign push_sel = push ? (pend_q & (~pend_q + 1'b1)) : '0;

    always_comb begin
        push_idx = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (pend_q[i]) push_idx = IDX_W'(i);
        end
    end

    assign push_rec.idx   = push_idx;
    assign push_rec.level = plev_q[push_idx];

    assign merge_vec = chg & pend_q & ~push_sel;
    assign pend_d    = chg | (pend_q & ~push_sel);
    assign plev_d    = (chg & sw_db) | (~chg & plev_q);

    always_comb begin
        merged_d = merged_q;
        if (clr_merged)        merged_d = 1'b0;
        if (merge_vec != '0)   merged_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_sw_q <= '0;
            pend_q    <= '0;
            plev_q    <= '0;
            merged_q  <= 1'b0;
        end else begin
            prev_sw_q <= sw_db;
            pend_q    <= pend_d;
            plev_q    <= plev_d;
            merged_q  <= merged_d;
        end
    end

    sync_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_rec),
        .pop_i   (pop),
        .data_o  (head_rec),
        .valid_o (ev_valid),
        .full_o  (fifo_full),
        .count_o (ev_count)
    );

    assign ev_idx    = head_rec.idx;
    assign ev_level  = head_rec.level;
    assign ev_merged = merged_q;

endmodule

// File: tb/tb_sw_event_queue.sv
// Directed bench for sw_event_queue: reset, latency, ordering, full FIFO,
// merge flag and mid-operation reset, with hand-computed expectations.
module tb_sw_event_queue;
    import sw_event_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_SW-1:0] sw_db;
    logic              ev_valid;
    logic              ev_ready;
    logic [IDX_W-1:0]  ev_idx;
    logic              ev_level;
    logic [CNT_W-1:0]  ev_count;
    logic              ev_merged;
    logic              clr_merged;

    int errors = 0;
    int checks = 0;

    sw_event_queue dut (
        .clk        (clk),
        .rst        (rst),
        .sw_db      (sw_db),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_idx     (ev_idx),
        .ev_level   (ev_level),
        .ev_count   (ev_count),
        .ev_merged  (ev_merged),
        .clr_merged (clr_merged)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic v, input int idx, input logic lvl, input int cnt);
        check({tag, ".valid"}, 32'(ev_valid), 32'(v));
        if (v) begin
            check({tag, ".idx"},   32'(ev_idx),   32'(idx));
            check({tag, ".level"}, 32'(ev_level), 32'(lvl));
        end
        check({tag, ".count"}, 32'(ev_count), 32'(cnt));
    endtask

    initial begin
        rst = 1'b0; sw_db = '0; ev_ready = 1'b0; clr_merged = 1'b0;
        #2;
        check_head("rst_hold", 1'b0, 0, 1'b0, 0);
        check("rst_idx", 32'(ev_idx), 32'd0);
        check("rst_merged", 32'(ev_merged), 32'd0);
        tick(); tick();
        rst = 1'b1;

        // Idle after reset: nothing may appear.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_valid", 32'(ev_valid), 32'd0);
            check("idle_count", 32'(ev_count), 32'd0);
        end

        // Single rise with consumer ready: visible for exactly one cycle.
        sw_db[3] = 1'b1; ev_ready = 1'b1;
        tick(); check_head("t2_k",   1'b0, 0, 1'b0, 0);
        tick(); check_head("t2_k1",  1'b1, 3, 1'b1, 1);
        tick(); check_head("t2_pop", 1'b0, 0, 1'b0, 0);
        tick(); check_head("t2_idle", 1'b0, 0, 1'b0, 0);

        // Three simultaneous rises queue in index order.
        ev_ready = 1'b0;
        sw_db[0] = 1'b1; sw_db[5] = 1'b1; sw_db[16] = 1'b1;
        tick(); check_head("t3_pend", 1'b0, 0, 1'b0, 0);
        tick(); check_head("t3_p1", 1'b1, 0, 1'b1, 1);
        tick(); check_head("t3_p2", 1'b1, 0, 1'b1, 2);
        tick(); check_head("t3_p3", 1'b1, 0, 1'b1, 3);
        tick(); check_head("t3_hold", 1'b1, 0, 1'b1, 3);
        ev_ready = 1'b1;
        tick(); check_head("t3_d1", 1'b1, 5, 1'b1, 2);
        tick(); check_head("t3_d2", 1'b1, 16, 1'b1, 1);
        tick(); check_head("t3_d3", 1'b0, 0, 1'b0, 0);

        // Five rises against a 4-deep FIFO: fifth waits until a pop frees a slot.
        ev_ready = 1'b0;
        sw_db[1] = 1'b1; sw_db[2] = 1'b1; sw_db[4] = 1'b1; sw_db[6] = 1'b1; sw_db[8] = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check_head("t4_full", 1'b1, 1, 1'b1, 4);
        tick(); check_head("t4_stay", 1'b1, 1, 1'b1, 4);
        ev_ready = 1'b1;
        tick(); check_head("t4_swap", 1'b1, 2, 1'b1, 4);
        ev_ready = 1'b0;

        // Full FIFO: switch 7 rises then falls while pending -> merged into one fall record.
        sw_db[7] = 1'b1;
        tick(); check("t5_nomerge", 32'(ev_merged), 32'd0);
        sw_db[7] = 1'b0;
        tick(); check("t5_merged", 32'(ev_merged), 32'd1);
        check("t5_count", 32'(ev_count), 32'd4);
        ev_ready = 1'b1;
        tick(); check_head("t5_d1", 1'b1, 4, 1'b1, 4);
        tick(); check_head("t5_d2", 1'b1, 6, 1'b1, 3);
        tick(); check_head("t5_d3", 1'b1, 8, 1'b1, 2);
        tick(); check_head("t5_d4", 1'b1, 7, 1'b0, 1);
        tick(); check_head("t5_d5", 1'b0, 0, 1'b0, 0);
        check("t5_sticky", 32'(ev_merged), 32'd1);
        clr_merged = 1'b1;
        tick(); check("t5_clr", 32'(ev_merged), 32'd0);
        clr_merged = 1'b0;

        // Mid-operation reset with three stored and one pending.
        ev_ready = 1'b0;
        sw_db[9] = 1'b1; sw_db[10] = 1'b1; sw_db[11] = 1'b1; sw_db[12] = 1'b1;
        tick(); tick(); tick(); tick();
        check_head("t6_pre", 1'b1, 9, 1'b1, 3);
        #2 rst = 1'b0;
        #1;
        check_head("t6_rst", 1'b0, 0, 1'b0, 0);
        check("t6_rst_idx", 32'(ev_idx), 32'd0);
        check("t6_rst_merged", 32'(ev_merged), 32'd0);
        sw_db = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_head("t6_post", 1'b0, 0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
